// File: rtl/host_wb_master.sv
// Single-outstanding Wishbone pipelined master.
// Turns a host req/done handshake into one WB transaction at a time, with
// bounded retry on rty and a per-attempt timeout. All outputs are registered.
module host_wb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned RETRIES    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [31:0]           dat_i,
  input  logic [3:0]            sel_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [31:0]           rdata_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RetryMax = 4'(RETRIES);

  localparam logic [1:0] StatOk  = 2'b00;
  localparam logic [1:0] StatErr = 2'b01;
  localparam logic [1:0] StatRty = 2'b10;
  localparam logic [1:0] StatTmo = 2'b11;

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StGap} state_e;

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [1:0]            status_q, status_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [3:0]            retry_q, retry_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  term;
  logic [1:0]            code;

  // Next-state and next-output decode; a terminating response overrides everything else.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    status_d = status_q;
    rdata_d  = rdata_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    term     = 1'b0;
    code     = StatOk;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = adr_i;
          sel_d   = sel_i;
          dat_d   = dat_i;
          retry_d = '0;
          tmo_d   = '0;
          state_d = StStrobe;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StStrobe, StWait: begin
        if (state_q == StStrobe && !wb_stall_i) begin
          state_d = StWait;
          stb_d   = 1'b0;
        end
        // err > ack > rty; any response beats a same-cycle timeout expiry
        if (wb_err_i) begin
          term = 1'b1;
          code = StatErr;
        end else if (wb_ack_i) begin
          term = 1'b1;
          code = StatOk;
          if (!we_q) rdata_d = wb_dat_i;
        end else if (wb_rty_i) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 4'd1;
            state_d = StGap;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
          end else begin
            term = 1'b1;
            code = StatRty;
          end
        end else if (tmo_q == TmoLast) begin
          term = 1'b1;
          code = StatTmo;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StGap: begin
        state_d = StStrobe;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        tmo_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (term) begin
      state_d  = StIdle;
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      status_d = code;
    end
  end

  // State and output registers; reset drops the bus immediately without a done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= '0;
      rdata_q  <= '0;
      retry_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign status_o = status_q;
  assign rdata_o  = rdata_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_host_wb_master.sv
// Bench for host_wb_master: scripted WB slave stub, directed vector table,
// reset-in-WAIT sequence and randomized transactions against an attempt-level model.
module tb_host_wb_master;

  localparam int AW = 32;
  localparam int T  = 8;
  localparam int R  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0] adr_i = '0;
  logic [31:0]   dat_i = '0;
  logic [3:0]    sel_i = '0;
  logic          busy_o, done_o;
  logic [1:0]    status_o;
  logic [31:0]   rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
  logic [31:0]   wb_dat_i = '0;

  always #5 clk = ~clk;

  host_wb_master #(.ADDR_WIDTH(AW), .TIMEOUT(T), .RETRIES(R)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .sel_i(sel_i), .busy_o(busy_o), .done_o(done_o),
    .status_o(status_o), .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
  );

  // resp bits are {err, ack, rty}; first n_pre attempts answer rty at resp_at
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall_n;
    int          resp_at;
    logic [2:0]  resp;
    int          n_pre;
    logic [1:0]  exp_status;
    int          exp_cyc;
    int          exp_gaps;
    int          exp_stb;
  } vec_t;

  int          n_tests = 0, n_fail = 0;
  int          p_stall_n = 0, p_resp_at = 1000, p_n_pre = 0;
  logic [2:0]  p_resp = 3'b000;
  bit          noise = 1'b0;
  int          att = -1, idx = 0;
  bit          prev_cyc = 1'b0;
  logic [31:0] mem [16];
  logic [31:0] mdl [16];
  logic [31:0] exp_rdata = '0;
  vec_t        tbl [14];

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Slave stub: decides next-cycle responses from the current (registered) master outputs.
  always @(negedge clk) begin
    logic [2:0]  rsp;
    logic [31:0] m;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        att = att + 1;
        idx = 0;
      end else begin
        idx = idx + 1;
      end
      rsp = 3'b000;
      if (idx == p_resp_at) rsp = (att < p_n_pre) ? 3'b001 : p_resp;
      wb_stall_i = wb_stb_o && (idx < p_stall_n);
      {wb_err_i, wb_ack_i, wb_rty_i} = rsp;
      wb_dat_i = mem[wb_adr_o[3:0]];
      if (rsp[1] && !rsp[2] && wb_we_o) begin
        m = bmask(wb_sel_o);
        mem[wb_adr_o[3:0]] = (mem[wb_adr_o[3:0]] & ~m) | (wb_dat_o & m);
      end
    end else if (noise) begin
      {wb_err_i, wb_ack_i, wb_rty_i, wb_stall_i} = 4'($urandom_range(0, 15));
      wb_dat_i = $urandom;
    end else begin
      {wb_err_i, wb_ack_i, wb_rty_i, wb_stall_i} = 4'b0000;
      wb_dat_i = '0;
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Attempt-level reference: each attempt lasts until its response or the timeout cycle.
  function automatic vec_t model(input vec_t v);
    int         endi;
    logic [2:0] r;
    bit         fin;
    v.exp_cyc = 0; v.exp_gaps = 0; v.exp_stb = 0; v.exp_status = 2'b11;
    fin = 1'b0;
    for (int a = 0; a <= R; a++) begin
      if (!fin) begin
        r = (a < v.n_pre) ? 3'b001 : v.resp;
        if (r != 3'b000 && v.resp_at <= T - 1) endi = v.resp_at;
        else begin
          endi = T - 1;
          r = 3'b000;
        end
        v.exp_cyc += endi + 1;
        v.exp_stb += ((v.stall_n < endi) ? v.stall_n : endi) + 1;
        if (r[2])            begin v.exp_status = 2'b01; fin = 1'b1; end
        else if (r[1])       begin v.exp_status = 2'b00; fin = 1'b1; end
        else if (r == 3'b0)  begin v.exp_status = 2'b11; fin = 1'b1; end
        else if (a < R)      v.exp_gaps++;
        else                 begin v.exp_status = 2'b10; fin = 1'b1; end
      end
    end
    return v;
  endfunction

  // Issue one request at the current negedge and check it through to done_o.
  task automatic run_txn(input string tag, input vec_t v);
    int n = 0, cyc_n = 0, stb_n = 0, gap_n = 0;
    bit seen = 1'b0, stable = 1'b1;
    p_stall_n = v.stall_n; p_resp_at = v.resp_at; p_resp = v.resp; p_n_pre = v.n_pre;
    att = -1;
    req_i = 1'b1; we_i = v.we; adr_i = v.adr; dat_i = v.dat; sel_i = v.sel;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
      else begin
        if (wb_cyc_o) begin
          cyc_n++;
          if (wb_stb_o) stb_n++;
          if (wb_adr_o !== v.adr || wb_dat_o !== v.dat || wb_sel_o !== v.sel ||
              wb_we_o !== v.we) stable = 1'b0;
        end else if (busy_o) gap_n++;
        // requests while busy must be ignored
        req_i = 1'($urandom_range(0, 1));
        we_i = 1'($urandom_range(0, 1));
        adr_i = $urandom; dat_i = $urandom; sel_i = 4'($urandom_range(0, 15));
      end
    end
    req_i = 1'b0;
    if (v.exp_status == 2'b00 && v.we)
      mdl[v.adr[3:0]] = (mdl[v.adr[3:0]] & ~bmask(v.sel)) | (v.dat & bmask(v.sel));
    if (v.exp_status == 2'b00 && !v.we) exp_rdata = mdl[v.adr[3:0]];
    chk({tag, " done seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, n, v.exp_cyc + v.exp_gaps + 1);
    chk({tag, " status"}, 32'(status_o), 32'(v.exp_status));
    chk({tag, " cyc cycles"}, cyc_n, v.exp_cyc);
    chk({tag, " stb cycles"}, stb_n, v.exp_stb);
    chk({tag, " gap cycles"}, gap_n, v.exp_gaps);
    chk({tag, " idle at done"}, {busy_o, wb_cyc_o, wb_stb_o}, 3'b000);
    chk({tag, " rdata"}, rdata_o, exp_rdata);
    chk({tag, " bus stable"}, 32'(stable), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      mdl[i] = '0;
    end
    //         we    adr     dat           sel  stl at  resp    pre st     cyc gap stb
    tbl[0]  = '{1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 0, 2,  3'b010, 0, 2'b00, 3,  0, 1};
    tbl[1]  = '{1'b0, 32'h0, 32'h0,        4'hF, 0, 1,  3'b010, 0, 2'b00, 2,  0, 1};
    tbl[2]  = '{1'b0, 32'h0, 32'h0,        4'hF, 0, 0,  3'b010, 2, 2'b00, 3,  2, 3};
    tbl[3]  = '{1'b1, 32'h1, 32'h12345678, 4'h3, 0, 0,  3'b001, 0, 2'b10, 4,  3, 4};
    tbl[4]  = '{1'b0, 32'h0, 32'h0,        4'hF, 0, 0,  3'b000, 0, 2'b11, 8,  0, 1};
    tbl[5]  = '{1'b1, 32'h4, 32'h11111111, 4'hF, 0, 1,  3'b110, 0, 2'b01, 2,  0, 1};
    tbl[6]  = '{1'b1, 32'h2, 32'hAAAA5555, 4'h5, 0, 7,  3'b010, 0, 2'b00, 8,  0, 1};
    tbl[7]  = '{1'b0, 32'h2, 32'h0,        4'hF, 3, 1,  3'b010, 0, 2'b00, 2,  0, 2};
    tbl[8]  = '{1'b0, 32'h1, 32'h0,        4'hF, 2, 4,  3'b010, 0, 2'b00, 5,  0, 3};
    tbl[9]  = '{1'b0, 32'h0, 32'h0,        4'hF, 0, 1,  3'b011, 0, 2'b00, 2,  0, 1};
    tbl[10] = '{1'b1, 32'h5, 32'h22222222, 4'hF, 0, 0,  3'b101, 0, 2'b01, 1,  0, 1};
    tbl[11] = '{1'b0, 32'h2, 32'h0,        4'hF, 20, 20, 3'b000, 0, 2'b11, 8, 0, 8};
    tbl[12] = '{1'b1, 32'h6, 32'h33333333, 4'hF, 0, 7,  3'b100, 1, 2'b01, 16, 1, 2};
    tbl[13] = '{1'b0, 32'h0, 32'h0,        4'hF, 0, 8,  3'b010, 0, 2'b11, 8,  0, 1};

    repeat (3) @(negedge clk);
    chk("reset ctrl", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, status_o}, '0);
    chk("reset adr", wb_adr_o, 32'h0);
    chk("reset dat", wb_dat_o, 32'h0);
    chk("reset sel/rdata", {28'h0, wb_sel_o} | rdata_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back (each request lands on the prior done cycle)
    for (int k = 0; k < 14; k++) begin
      run_txn($sformatf("vec%0d", k), tbl[k]);
      if (k == 0) chk("r1 bank value", mem[0], 32'hDEADBEEF);
      if (k == 1) chk("r1 readback", rdata_o, 32'hDEADBEEF);
    end
    @(negedge clk);
    chk("done one cycle", 32'(done_o), 32'd0);

    // Reset while waiting for a response
    p_stall_n = 0; p_resp_at = 1000; p_resp = 3'b000; p_n_pre = 0; att = -1;
    req_i = 1'b1; we_i = 1'b1; adr_i = 32'h3; dat_i = 32'hCAFEF00D; sel_i = 4'hF;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("wait busy", {busy_o, wb_cyc_o, wb_stb_o}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset", {wb_cyc_o, wb_stb_o, busy_o, done_o}, 4'b0000);
    @(negedge clk);
    chk("no done after reset", {done_o, status_o, rdata_o}, '0);
    rst_n = 1'b1;
    exp_rdata = '0;
    v = '{1'b1, 32'h3, 32'h0BADBEEF, 4'hF, 0, 1, 3'b010, 0, 2'b00, 0, 0, 0};
    run_txn("post reset", model(v));

    // Randomized transactions with bus noise outside cyc
    noise = 1'b1;
    for (int k = 0; k < 60; k++) begin
      v.we = 1'($urandom_range(0, 1));
      v.adr = $urandom; v.dat = $urandom; v.sel = 4'($urandom_range(0, 15));
      v.stall_n = $urandom_range(0, 3);
      v.resp_at = $urandom_range(v.stall_n, 9);
      v.resp = 3'($urandom_range(0, 7));
      v.n_pre = $urandom_range(0, 4);
      run_txn($sformatf("rnd%0d", k), model(v));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    noise = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_wb_master.md
Name: host_wb_master

Overview:
- Single-outstanding Wishbone pipelined master, one level upstream of the generated register-bank slaves (e.g. the r1 bank).
- Converts a simple host request/done interface into one WB transaction at a time, driving cyc/stb/we/sel/adr/dat.
- Handles stall, ack, err and rty from the slave, with bounded retry and a per-attempt timeout.
- Returns read data and a 2-bit status to the host.

Parameters:
- ADDR_WIDTH, 32, width of host and WB address.
- TIMEOUT, 255, cycles per attempt before abort; legal range 2..65535.
- RETRIES, 3, maximum re-issues after rty; legal range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- req_i  in  1  host request; sampled only when busy_o=0.
- we_i  in  1  host write enable.
- adr_i  in  ADDR_WIDTH  host address.
- dat_i  in  32  host write data.
- sel_i  in  4  host byte selects.
- busy_o  out  1  transaction in progress.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  2  completion code: 00 ok, 01 bus error, 10 retries exhausted, 11 timeout; valid with done_o, held until next done_o.
- rdata_o  out  32  read data; valid with done_o for an ok read, held otherwise.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WB master controls.
- wb_adr_o  out  ADDR_WIDTH  WB address.
- wb_sel_o  out  4  WB byte selects.
- wb_dat_o  out  32  WB write data.
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each  WB slave responses.
- wb_dat_i  in  32  WB read data.

Behaviour:
- All outputs are registered. On reset every output is 0 and the FSM is IDLE. Reset mid-transaction drops cyc/stb immediately, with no done_o pulse.
- FSM states: IDLE, STROBE, WAIT, GAP.
- IDLE:
  - req_i=1 at cycle N latches we/adr/dat/sel and clears the retry and timeout counters.
  - At N+1: STROBE, cyc=stb=1, busy_o=1.
- STROBE: stb held until a cycle with wb_stall_i=0.
  - If that cycle also has a response: terminate.
  - Otherwise: WAIT, with stb=0 and cyc=1.
- WAIT: cyc held until a response.
- Response priority when signals coincide: err > ack > rty.
  - ack: terminate ok. For reads, rdata_o captures wb_dat_i in the ack cycle.
  - err: terminate with status 01.
  - rty with retry count < RETRIES: increment the count, go to GAP (cyc=stb=0 for exactly one cycle), then STROBE again with the same address and data.
  - rty with count == RETRIES: terminate with status 10.
- Terminate: if the response arrives at cycle M, then at M+1 cyc=stb=0, done_o=1, busy_o=0, state IDLE. A req_i at M+1 is accepted, so its cyc starts at M+2.
- Timeout counter:
  - Cleared on entry to STROBE.
  - Increments every STROBE/WAIT cycle without a response.
  - Reaching TIMEOUT-1 with no response that cycle terminates with status 11.
  - A response in the same cycle as expiry takes precedence.
- req_i while busy_o=1 is ignored, not queued.
- Responses in IDLE or GAP are ignored.
- ack together with stall=1 in STROBE is treated as a normal ack.
- wb_dat_o, wb_adr_o, wb_sel_o and wb_we_o are stable from the first stb cycle until cyc drops.

Test Plan:
- Write to a generated r1 bank (pipelined write/read, ack on the 3rd cyc cycle), adr=0, dat=0xDEADBEEF, sel=0xF -> cyc high 3 cycles; done_o one cycle later with status 00; r1_o=0xDEADBEEF.
- Read-back of the same bank -> done_o with status 00 and rdata_o=0xDEADBEEF; cyc high exactly 2 cycles.
- Stub asserting rty on the first 2 attempts and ack on the 3rd (RETRIES=3) -> 2 GAP cycles with cyc=0, status 00. Stub with rty always -> 4 strobes total, then status 10.
- Stub never responding, TIMEOUT=8 -> cyc high exactly 8 cycles, then done_o with status 11 and rdata_o unchanged.
- Stub driving err and ack in the same cycle -> status 01. ack on the same cycle as timeout expiry -> status 00.
- rst_n_i pulled low in WAIT -> cyc/stb/busy/done go to 0 asynchronously. The next req_i after reset release completes with status 00.
